// File: rtl/alu_mdu_decoder.sv
// ALU control decoder with an iterative RV32M/RV64M multiply/divide unit.
// The MDU takes one bit per cycle and raises stall while it is busy.
module alu_mdu_decoder #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            flush,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [1:0]      ALUOp,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [3:0]      ALUControl,
  output logic            mext_op,
  output logic            stall,
  output logic            mdu_valid,
  output logic [XLEN-1:0] mdu_result
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state_q, state_d;

  logic sub_sra;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sub_sra    = funct7[5] & opcode[5];
    ALUControl = 4'b0000;
    case (ALUOp)
      2'b01: begin
        case (funct3)
          3'b000:  ALUControl = 4'b0001;
          3'b001:  ALUControl = 4'b1010;
          3'b100:  ALUControl = 4'b1011;
          3'b101:  ALUControl = 4'b1100;
          default: ALUControl = 4'b0000;
        endcase
      end
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = sub_sra ? 4'b0001 : 4'b0000;
          3'b001:  ALUControl = 4'b0111;
          3'b010:  ALUControl = 4'b0101;
          3'b011:  ALUControl = 4'b0110;
          3'b100:  ALUControl = 4'b0100;
          3'b101:  ALUControl = sub_sra ? 4'b1001 : 4'b1000;
          3'b110:  ALUControl = 4'b0011;
          default: ALUControl = 4'b0010;
        endcase
      end
      default: ALUControl = 4'b0000;
    endcase
  end

  assign mext_op = ENABLE_M && (opcode == 7'b0110011) && (funct7 == 7'b0000001) && (ALUOp == 2'b10);

  logic            accept, sign_a, sign_b, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  // Operands are reduced to magnitudes; the sign fix-up happens once at the end.
  always_comb begin
    accept = valid_i & mext_op & ~flush;
    if (funct3[2]) begin
      sign_a = ~funct3[0] & rs1_val[XLEN-1];
      sign_b = ~funct3[0] & rs2_val[XLEN-1];
    end else begin
      sign_a = (funct3[1:0] != 2'b11) & rs1_val[XLEN-1];
      sign_b = ~funct3[1] & rs2_val[XLEN-1];
    end
    mag_a    = sign_a ? -rs1_val : rs1_val;
    mag_b    = sign_b ? -rs2_val : rs2_val;
    div_zero = funct3[2] & (rs2_val == '0);
    div_ovf  = funct3[2] & ~funct3[0] & (rs1_val == MIN_INT) & (rs2_val == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = funct3[1] ? rs1_val : '1;
    else          special_res = funct3[1] ? '0 : MIN_INT;
  end

  logic [2*XLEN-1:0] p_q, mul_step, div_step, step_p, prod_signed;
  logic [XLEN-1:0]   b_q, quo, rem, fin_res, pending_q, held_q;
  logic [XLEN:0]     hi_sum, rem_shift, diff;
  logic [1:0]        f3_q;
  logic [CW-1:0]     count_q;
  logic              neg_q, sign_a_q;

  // p_q holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    hi_sum    = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : '0);
    mul_step  = {hi_sum, p_q[XLEN-1:1]};
    rem_shift = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    diff      = rem_shift - {1'b0, b_q};
    div_step  = diff[XLEN] ? {rem_shift[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    step_p      = (state_q == MUL) ? mul_step : div_step;
    prod_signed = neg_q ? -step_p : step_p;
    quo         = neg_q ? -step_p[XLEN-1:0] : step_p[XLEN-1:0];
    rem         = sign_a_q ? -step_p[2*XLEN-1:XLEN] : step_p[2*XLEN-1:XLEN];
    if (state_q == MUL)
      fin_res = (f3_q == 2'b00) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
    else
      fin_res = f3_q[1] ? rem : quo;
  end

  // NOTE: the datapath has no reset; every field is loaded on acceptance before it is read.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && accept) begin
      p_q      <= {{XLEN{1'b0}}, mag_a};
      b_q      <= mag_b;
      neg_q    <= sign_a ^ sign_b;
      sign_a_q <= sign_a;
      f3_q     <= funct3[1:0];
      count_q  <= '0;
    end else if (state_q == MUL || state_q == DIV) begin
      p_q     <= step_p;
      count_q <= count_q + CW'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      held_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept && special)
        pending_q <= special_res;
      else if ((state_q == MUL || state_q == DIV) && count_q == LAST && !flush)
        pending_q <= fin_res;
      if (mdu_valid)
        held_q <= pending_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = !funct3[2] ? MUL : (special ? DONE : DIV);
      MUL, DIV: begin
        if (flush)                 state_d = IDLE;
        else if (count_q == LAST)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A flushed or reset DONE cycle never publishes its pending result.
  always_comb begin
    stall      = (state_q == MUL) || (state_q == DIV) || (state_q == IDLE && valid_i && mext_op);
    mdu_valid  = (state_q == DONE) && !flush && !rst;
    mdu_result = mdu_valid ? pending_q : held_q;
  end

endmodule

// File: tb/tb_alu_mdu_decoder.sv
// Randomized self-checking bench for alu_mdu_decoder (XLEN=32) against an arithmetic model.
module tb_alu_mdu_decoder;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1, valid_i = 1'b0, flush = 1'b0;
  logic [6:0]      opcode = '0, funct7 = '0;
  logic [2:0]      funct3 = '0;
  logic [1:0]      ALUOp = '0;
  logic [XLEN-1:0] rs1_val = '0, rs2_val = '0;
  logic [3:0]      ALUControl;
  logic            mext_op, stall, mdu_valid;
  logic [XLEN-1:0] mdu_result;

  int          n_checks = 0, n_errors = 0;
  logic [31:0] last_result = '0;

  alu_mdu_decoder #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush(flush), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .ALUOp(ALUOp), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .ALUControl(ALUControl), .mext_op(mext_op), .stall(stall), .mdu_valid(mdu_valid),
    .mdu_result(mdu_result)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_alu(logic [1:0] op, logic [2:0] f3, logic [6:0] f7, logic [6:0] opc);
    logic alt;
    alt = f7[5] && opc[5];
    if (op == 2'b01) begin
      if (f3 == 3'b000) return 4'b0001;
      if (f3 == 3'b001) return 4'b1010;
      if (f3 == 3'b100) return 4'b1011;
      return 4'b1100;
    end
    if (op != 2'b10) return 4'b0000;
    case (f3)
      3'b000:  return alt ? 4'b0001 : 4'b0000;
      3'b001:  return 4'b0111;
      3'b010:  return 4'b0101;
      3'b011:  return 4'b0110;
      3'b100:  return 4'b0100;
      3'b101:  return alt ? 4'b1001 : 4'b1000;
      3'b110:  return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [31:0] ref_mop(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p, tq, tr;
    longint      sa, sb;
    if (!f3[2]) begin
      ea = (f3[1:0] != 2'b11) ? {{32{a[31]}}, a} : {32'h0, a};
      eb = (!f3[1])           ? {{32{b[31]}}, b} : {32'h0, b};
      p  = ea * eb;
      return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
    end
    if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    tq = sa / sb;
    tr = sa % sb;
    return f3[1] ? tr[31:0] : tq[31:0];
  endfunction

  function automatic bit is_special(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    return f3[2] && (b == 32'h0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic dec_check(input string tag, input logic [1:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [6:0] opc, input logic [3:0] exp);
    @(negedge clk);
    valid_i = 1'b0; ALUOp = op; funct3 = f3; funct7 = f7; opcode = opc;
    #1;
    check(tag, ALUControl, exp);
  endtask

  task automatic drive_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1; opcode = 7'b0110011; funct7 = 7'b0000001; ALUOp = 2'b10;
    funct3 = f3; rs1_val = a; rs2_val = b;
  endtask

  task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int exp_lat, lat, stall_cycles;
    bit seen;
    exp_lat = is_special(f3, a, b) ? 1 : XLEN + 1;
    @(negedge clk);
    drive_mop(f3, a, b);
    #1;
    stall_cycles = stall ? 1 : 0;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= XLEN + 8 && !seen; n++) begin
      @(negedge clk);
      rs1_val = $urandom;
      rs2_val = $urandom;
      #1;
      if (mdu_valid) begin
        seen = 1'b1;
        lat  = n;
      end else if (stall) begin
        stall_cycles++;
      end
    end
    check({tag, "_seen"}, seen, 1'b1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_stall_cycles"}, stall_cycles, exp_lat);
    check({tag, "_done_stall"}, stall, 1'b0);
    check({tag, "_result"}, mdu_result, exp);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    check({tag, "_one_pulse"}, mdu_valid, 1'b0);
    check({tag, "_held"}, mdu_result, exp);
    last_result = exp;
  endtask

  task automatic abort_mop(input bit use_rst);
    int pulses;
    @(negedge clk);
    drive_mop(3'b100, 32'd100, 32'd7);
    for (int n = 1; n <= 10; n++) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         flush = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    #1;
    check(use_rst ? "rst_idle" : "flush_idle", stall, 1'b0);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (mdu_valid) pulses++;
    end
    check(use_rst ? "rst_no_valid" : "flush_no_valid", pulses, 0);
    if (use_rst) last_result = 32'h0;
    check(use_rst ? "rst_result" : "flush_result", mdu_result, last_result);
  endtask

  initial begin
    logic [1:0] op;
    logic [2:0] f3;
    logic [6:0] f7, opc;
    logic [31:0] a, b;
    int pulses;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_stall", stall, 1'b0);
    check("reset_valid", mdu_valid, 1'b0);
    check("reset_result", mdu_result, 32'h0);

    dec_check("dec_sub", 2'b10, 3'b000, 7'b0100000, 7'b0110011, 4'b0001);
    dec_check("dec_addi", 2'b10, 3'b000, 7'b0100000, 7'b0010011, 4'b0000);
    dec_check("dec_sra", 2'b10, 3'b101, 7'b0100000, 7'b0110011, 4'b1001);
    dec_check("dec_jalr", 2'b11, 3'b111, 7'b0000000, 7'b1100111, 4'b0000);
    dec_check("dec_bltu", 2'b01, 3'b100, 7'b0000000, 7'b1100011, 4'b1011);
    for (int i = 0; i < 24; i++) begin
      op  = 2'($urandom_range(0, 3));
      f3  = 3'($urandom_range(0, 7));
      if (op == 2'b01) f3 = {f3[1], 1'b0, f3[0]};
      case ($urandom_range(0, 3))
        0: f7 = 7'b0000000;
        1: f7 = 7'b0100000;
        2: f7 = 7'b0000001;
        default: f7 = 7'($urandom);
      endcase
      opc = $urandom_range(0, 1) ? 7'b0110011 : 7'b0010011;
      dec_check("dec_rand", op, f3, f7, opc, ref_alu(op, f3, f7, opc));
      check("mext_rand", mext_op, (opc == 7'b0110011 && f7 == 7'b0000001 && op == 2'b10));
    end

    run_mop("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_mop("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mop("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_mop("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14);
    run_mop("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_mop("div_by_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_mop("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_mop("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    abort_mop(1'b0);
    abort_mop(1'b1);

    // Flush arriving together with a would-be acceptance must block it.
    @(negedge clk);
    drive_mop(3'b000, 32'd3, 32'd4);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    valid_i = 1'b0;
    #1;
    check("idle_flush_stall", stall, 1'b0);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (mdu_valid) pulses++;
    end
    check("idle_flush_no_valid", pulses, 0);

    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_mop("mop_rand", f3, a, b, ref_mop(f3, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
